bird_frame_seq: RTL
===================

BIRD_FRAME_SEQ -- requirements
Module: bird_frame_seq

Interface
REQ-001 Parameter BIRD_X, default 8'd20: fixed left column of the 4x4 bird sprite.
REQ-002 Parameter Y_INIT, default 7'd60: bird top row after reset.
REQ-003 Parameter Y_MAX, default 7'd116: lowest legal top row (sprite bottom = 119).
REQ-004 Parameter FLAP_STEP, default 7'd4: pixels risen per flap.
REQ-005 Parameter MAX_FALL, default 7'd6: fall-speed ceiling, pixels/frame.
REQ-006 Parameter BIRD_COLOUR, default 3'b010: draw colour (green).
REQ-007 clk  input  1: single system clock; all state changes on posedge.
REQ-008 resetn  input  1: reset, synchronous, active-low.
REQ-009 frame_tick  input  1: one-cycle pulse per animation frame.
REQ-010 flap  input  1: active-high player button, already debounced.
REQ-011 x  output  8: VGA plot column.
REQ-012 y  output  7: VGA plot row.
REQ-013 colour  output  3: VGA plot colour.
REQ-014 plot  output  1: write-enable to the VGA adapter, one pixel per asserted cycle.
REQ-015 bird_y  output  7: current bird top row.
REQ-016 busy  output  1: high while not in IDLE or DEAD.
REQ-017 dead  output  1: sticky ground-collision flag.
REQ-018 overrun  output  1: sticky flag, frame_tick arrived while busy.

Function
REQ-019 FSM states SHALL be IDLE, ERASE, UPDATE, DRAW, DEAD.
REQ-020 IDLE + frame_tick: -> DRAW if drawn flag is 0 (first frame after reset), else -> ERASE.
REQ-021 ERASE: 16 cycles, colour=3'b000 at the old bird_y, then -> UPDATE.
REQ-022 UPDATE: 1 cycle, plot=0, applies physics (REQ-025..028), then -> DRAW.
REQ-023 DRAW: 16 cycles, colour=BIRD_COLOUR at the current bird_y, sets drawn=1, then -> IDLE, or -> DEAD if dead=1.
REQ-024 Pixel counter 4 bits, 0..15: x=BIRD_X+cnt[3:2], y=bird_y+cnt[1:0]; plot=1 on every ERASE/DRAW cycle and 0 otherwise; counter resets to 0 on every state entry.
REQ-025 Flap SHALL be rising-edge detected and latched as flap_pend at any cycle; one press gives exactly one flap; holding the button gives no repeat.
REQ-026 UPDATE with flap_pend=1: bird_y = bird_y-FLAP_STEP, clamped to 0 if bird_y<FLAP_STEP; speed=1; flap_pend cleared.
REQ-027 UPDATE with flap_pend=0: sum = bird_y+speed computed 8 bits wide; if sum>=Y_MAX then bird_y=Y_MAX and dead=1, else bird_y=sum; speed update per Configuration.
REQ-028 A flap edge in the same cycle as UPDATE SHALL be kept pending for the next frame, not applied.
REQ-029 Latency: frame_tick at cycle T -> first plot at T+1; for a non-first frame, ERASE T+1..T+16, UPDATE T+17, DRAW T+18..T+33, busy low at T+34.
REQ-030 frame_tick while busy SHALL be ignored and set overrun=1.
REQ-031 DEAD: plot=0, frame_tick and flap ignored; only reset exits.

Reset
REQ-032 When resetn=0 at posedge clk: state=IDLE, cnt=0, plot=0, x=0, y=0, colour=0, bird_y=Y_INIT, speed=1, drawn=0, flap_pend=0, dead=0, overrun=0, busy=0.
REQ-033 Reset asserted mid-ERASE/DRAW SHALL abort the sprite immediately, with no further plot cycles.

Configuration
REQ-034 Macro BIRD_GRAVITY_EN defined: after each non-flap UPDATE, speed=min(speed+1, MAX_FALL).
REQ-035 BIRD_GRAVITY_EN undefined: speed held at 1; constant fall of 1 pixel/frame.

Verification
REQ-036 Reset, one frame_tick -> 16 plots, colour 010, at x 20..23, y 60..63; no erase; bird_y=60.
REQ-037 With BIRD_GRAVITY_EN, ticks 2,3,4 with no flap -> each erases old position first; bird_y 61, 63, 66.
REQ-038 bird_y=63, flap pulse between frames, then tick -> erase at rows 63..66, bird_y=59, speed=1; holding flap through the next tick -> bird_y=60 (no second flap).
REQ-039 bird_y=2, flap, tick -> bird_y=0; bird_y=114, speed 3, tick -> bird_y=116, dead=1, DRAW completes, then DEAD; later ticks produce no plot.
REQ-040 frame_tick at T+5 of a frame -> overrun=1, sequence unchanged; resetn low at T+20 -> plot=0 next cycle, bird_y=60.

Source files
------------

// File: rtl/bird_frame_seq.sv
// bird_frame_seq: erase/update/draw sequencer for a 4x4 flappy-bird sprite on a VGA plot port.
// Define BIRD_GRAVITY_EN for accelerating fall (speed grows to MAX_FALL); otherwise the fall is a constant 1 px/frame.
module bird_frame_seq #(
  parameter logic [7:0] BIRD_X      = 8'd20,
  parameter logic [6:0] Y_INIT      = 7'd60,
  parameter logic [6:0] Y_MAX       = 7'd116,
  parameter logic [6:0] FLAP_STEP   = 7'd4,
  parameter logic [6:0] MAX_FALL    = 7'd6,
  parameter logic [2:0] BIRD_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       flap,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [6:0] bird_y,
  output logic       busy,
  output logic       dead,
  output logic       overrun
);
`ifdef BIRD_GRAVITY_EN
  localparam bit GRAVITY = 1'b1;
`else
  localparam bit GRAVITY = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ERASE, UPDATE, DRAW, DEAD} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [6:0] speed, speed_n;
  logic [7:0] sum;
  logic drawn, flap_q, flap_pend, flap_rise, last;
  assign flap_rise = flap & ~flap_q;
  assign last = cnt == 4'd15;
  assign sum = {1'b0, bird_y} + {1'b0, speed};
  assign speed_n = !GRAVITY ? 7'd1 : (speed >= MAX_FALL ? MAX_FALL : speed + 7'd1);
  assign plot = state == ERASE || state == DRAW;
  assign busy = state != IDLE && state != DEAD;
  assign x = plot ? BIRD_X + {6'b0, cnt[3:2]} : 8'd0;
  assign y = plot ? bird_y + {5'b0, cnt[1:0]} : 7'd0;
  assign colour = state == DRAW ? BIRD_COLOUR : 3'b000;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = frame_tick ? (drawn ? ERASE : DRAW) : IDLE;
      ERASE:   state_n = last ? UPDATE : ERASE;
      UPDATE:  state_n = DRAW;
      DRAW:    state_n = last ? (dead ? DEAD : IDLE) : DRAW;
      DEAD:    state_n = DEAD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      bird_y    <= Y_INIT;
      speed     <= 7'd1;
      drawn     <= 1'b0;
      flap_q    <= 1'b0;
      flap_pend <= 1'b0;
      dead      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= plot ? cnt + 4'd1 : 4'd0;
      flap_q    <= flap;
      // an edge landing on the UPDATE cycle survives the clear and waits for the next frame
      flap_pend <= (state == UPDATE ? 1'b0 : flap_pend) | flap_rise;
      if (frame_tick && busy) overrun <= 1'b1;
      if (state == DRAW && last) drawn <= 1'b1;
      if (state == UPDATE && flap_pend) begin
        bird_y <= bird_y < FLAP_STEP ? 7'd0 : bird_y - FLAP_STEP;
        speed  <= 7'd1;
      end else if (state == UPDATE) begin
        bird_y <= sum >= {1'b0, Y_MAX} ? Y_MAX : sum[6:0];
        dead   <= sum >= {1'b0, Y_MAX};
        speed  <= speed_n;
      end
    end
  end
endmodule
